sw_input_conditioner: RTL



---
 rtl/sw_cond_pkg.sv | 13 +
 rtl/sw_debounce_ch.sv | 49 ++++
 rtl/sw_input_conditioner.sv | 85 ++++++++
 3 files changed

// File: rtl/sw_cond_pkg.sv
// Shared constants and event-FSM state type for the switch input conditioner.
package sw_cond_pkg;

  localparam int N_CH_DEF       = 16;
  localparam int STABLE_CYC_DEF = 1000000;
  localparam int STABLE_CYC_SIM = 8;

  typedef enum logic {
    EVT_IDLE  = 1'b0,
    EVT_VALID = 1'b1
  } evt_state_e;

endpackage

// File: rtl/sw_debounce_ch.sv
// One switch channel: 2-flop synchroniser, stability counter, debounced level, rise/fall strobes.
// Level follows the pin STABLE_CYC+2 edges after first sampling; no backpressure.
module sw_debounce_ch
  import sw_cond_pkg::*;
#(
  parameter int STABLE_CYC = STABLE_CYC_DEF
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic sw_i,
  output logic sw_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CNT_W = $clog2(STABLE_CYC);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      cnt    <= '0;
      sw_o   <= 1'b0;
      rise_o <= 1'b0;
      fall_o <= 1'b0;
    end else begin
      sync1  <= sw_i;
      sync2  <= sync1;
      rise_o <= 1'b0;
      fall_o <= 1'b0;
      // Any cycle agreeing with the current level restarts the stability run.
      if (sync2 == sw_o) begin
        cnt <= '0;
      end else if (cnt != CNT_W'(STABLE_CYC - 1)) begin
        cnt <= cnt + 1'b1;
      end else begin
        cnt    <= '0;
        sw_o   <= sync2;
        rise_o <= sync2;
        fall_o <= ~sync2;
      end
    end
  end

endmodule

// File: rtl/sw_input_conditioner.sv
// Switch front end: per-channel debounce plus a coalescing valid/ready change-event stream.
// Events appear 1 cycle after a level change; stalls coalesce into one pending snapshot and set sticky ovr_o.
module sw_input_conditioner
  import sw_cond_pkg::*;
#(
  parameter int N_CH       = N_CH_DEF,
  parameter int STABLE_CYC = STABLE_CYC_DEF
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic [N_CH-1:0] sw_i,
  output logic [N_CH-1:0] sw_o,
  output logic [N_CH-1:0] rise_o,
  output logic [N_CH-1:0] fall_o,
  output logic            evt_valid_o,
  input  logic            evt_ready_i,
  output logic [N_CH-1:0] evt_data_o,
  output logic            ovr_o,
  input  logic            ovr_clr_i
);

  if (STABLE_CYC < 2) begin : g_bad_stable_cyc
    $error("sw_input_conditioner: STABLE_CYC must be >= 2");
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    sw_debounce_ch #(
      .STABLE_CYC(STABLE_CYC)
    ) u_ch (
      .clk_i  (clk_i),
      .rstn_i (rstn_i),
      .sw_i   (sw_i[i]),
      .sw_o   (sw_o[i]),
      .rise_o (rise_o[i]),
      .fall_o (fall_o[i])
    );
  end

  logic       chg;
  logic       pending;
  evt_state_e state;

  assign chg = |(rise_o | fall_o);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state       <= EVT_IDLE;
      evt_valid_o <= 1'b0;
      evt_data_o  <= '0;
      pending     <= 1'b0;
      ovr_o       <= 1'b0;
    end else begin
      // A new overrun later in this block overrides a same-cycle clear.
      if (ovr_clr_i) ovr_o <= 1'b0;
      case (state)
        EVT_IDLE: begin
          if (chg) begin
            state       <= EVT_VALID;
            evt_valid_o <= 1'b1;
            evt_data_o  <= sw_o;
          end
        end
        EVT_VALID: begin
          if (!evt_ready_i) begin
            if (chg) begin
              pending <= 1'b1;
              ovr_o   <= 1'b1;
            end
          end else if (pending || chg) begin
            evt_data_o <= sw_o;
            pending    <= 1'b0;
          end else begin
            state       <= EVT_IDLE;
            evt_valid_o <= 1'b0;
          end
        end
        default: begin
          state       <= EVT_IDLE;
          evt_valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
